// File: rtl/data_memory.sv
// data_memory: word-organised data RAM with clocked stores, combinational loads and async clear
module data_memory #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * 4);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         index;
    logic                  in_range;

    assign index    = address[IW+1:2];
    assign in_range = address < LIMIT;

    // store on the rising edge; reset clears every word immediately and blocks stores
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (write_enable && in_range) begin
            mem[index] <= write_data;
        end
    end

    // load path: gated by strobe, reset and range, no bypass of a pending store
    always_comb begin
        read_data = (read_enable && !rst && in_range) ? mem[index] : '0;
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized scoreboard bench for data_memory against a word-array model
module tb_data_memory;
    localparam int DEPTH = 256;
    localparam int LIMIT = DEPTH * 4;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;

    logic [31:0] model [DEPTH];
    exp_t        sb [$];
    event        sample_ev;
    int          errors = 0;
    int          checks = 0;

    data_memory #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .write_data(write_data),
        .write_enable(write_enable),
        .read_enable(read_enable),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    // model view of a load: the containing word when enabled, out of reset and in range
    function automatic logic [31:0] expect_read(input logic [31:0] a, input logic re);
        if (!re || rst || a >= LIMIT) return 32'h0;
        return model[a / 4];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic push_check(input string name);
        exp_t e;
        #1;
        e.exp  = expect_read(address, read_enable);
        e.name = name;
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic read_check(input logic [31:0] a, input logic re, input string name);
        address     = a;
        read_enable = re;
        push_check(name);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        if (!rst && a < LIMIT) model[a / 4] = d;
        #1;
        write_enable = 1'b0;
    endtask

    // monitor: each sample strobe pops the oldest expectation and compares it with the DUT
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL monitor: sample with empty scoreboard, read_data=%h", read_data);
            end else begin
                e = sb.pop_front();
                checks++;
                if (read_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s: addr=%h got=%h expected=%h", e.name, address, read_data, e.exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired with %0d pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        model_clear();
        // asynchronous reset pulse away from any edge
        #3 rst = 1'b1;
        model_clear();
        read_check(32'h0, 1'b1, "read_during_rst");
        #1 rst = 1'b0;
        read_check(32'h0, 1'b1, "reset_0x0");
        read_check(32'h4, 1'b1, "reset_0x4");
        read_check(32'hFC, 1'b1, "reset_0xFC");

        write_word(32'h4, 32'hDEADBEEF);
        write_word(32'h8, 32'hCAFEBABE);
        read_check(32'h4, 1'b1, "load_0x4");
        read_check(32'h8, 1'b1, "load_0x8");

        read_check(32'h4, 1'b0, "gate_off");
        read_check(32'h4, 1'b1, "gate_on");

        read_check(32'h6, 1'b1, "misaligned_0x6");
        write_word(32'h0, 32'hA5A5A5A5);
        write_word(LIMIT, 32'h12345678);
        read_check(32'h0, 1'b1, "oob_no_alias");
        read_check(LIMIT, 1'b1, "oob_read");

        // read-during-write on the same word
        @(negedge clk);
        address      = 32'h8;
        read_enable  = 1'b1;
        write_data   = 32'h11111111;
        write_enable = 1'b1;
        push_check("rdw_before");
        @(posedge clk);
        model[2] = 32'h11111111;
        push_check("rdw_after");
        write_enable = 1'b0;

        // randomized mix of stores (some out of range) and loads
        for (int i = 0; i < 300; i++) begin
            a = 32'($urandom_range(0, LIMIT + 64));
            if ($urandom % 2 == 0) write_word(a, $urandom);
            else read_check(a, ($urandom % 4) != 0, "rand_read");
        end
        for (int i = 0; i < 64; i++) read_check(32'(i * 4), 1'b1, "sweep_read");

        // reset while a store is pending: nothing survives, the store is dropped
        for (int i = 0; i < 8; i++) write_word(32'(i * 8 + 16), $urandom | 32'h1);
        @(negedge clk);
        address      = 32'h10;
        write_data   = 32'hFFFFFFFF;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        rst          = 1'b1;
        model_clear();
        @(posedge clk);
        #2 rst = 1'b0;
        write_enable = 1'b0;
        read_check(32'h10, 1'b1, "rst_pending_write");
        for (int i = 0; i < 24; i++) read_check(32'(i * 4), 1'b1, "rst_cleared");

        #5;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised RAM serving as the data memory of the single-cycle RISC-V core; sits on the load/store path after the ALU address computation.
- Writes occur on the rising clock edge; reads are combinational so a load completes within the same cycle.
- Full 32-bit word accesses only; byte address is converted to a word index internally.

Parameters:
- DEPTH, 256, number of 32-bit words stored.
- ADDR_WIDTH, 32, width of the byte address input.
- DATA_WIDTH, 32, word width; fixed at 32 for this core.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- address  input  32  byte address of the access.
- write_data  input  32  word to store.
- write_enable  input  1  store strobe, sampled at rising clk.
- read_enable  input  1  load strobe, combinational.
- read_data  output  32  loaded word.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Word index = address[log2(DEPTH)+1:2].
- address[1:0] are ignored: misaligned addresses access the containing word.
- Address is in range when address < DEPTH*4.
- Reset:
  - Assertion of rst immediately clears every word to 0, without waiting for a clock edge.
  - While rst is high, read_data = 0 and writes are blocked.
  - Deassertion requires no clock edge; the memory is usable from the next rising edge.
- Write:
  - On a rising clk with rst=0, write_enable=1 and address in range, mem[index] <= write_data.
  - Write latency: 1 edge; the new data is visible combinationally right after that edge.
  - An out-of-range write is ignored, with no aliasing into valid words.
- Read:
  - read_data = mem[index] when read_enable=1, rst=0 and address in range; otherwise read_data = 32'h0.
  - read_data follows address and read_enable changes with zero cycle latency.
- Simultaneous read and write to the same index:
  - Before the edge, read_data shows the old word.
  - After the edge, it shows the new word.
  - No internal bypass.
- write_enable and read_enable are independent; both may be high at once.
- Contents persist indefinitely when no write occurs.
- No X propagation after reset; every word has a defined value.

Test Plan:
- Reset check: pulse rst mid-cycle, then set read_enable=1 at address 0x0, 0x4 and 0xFC -> read_data=0x00000000 at each, with no clock edge needed for the clear.
- Basic store/load:
  - Stimulus: write 0xDEADBEEF to 0x4 and 0xCAFEBABE to 0x8 (one edge each), drop write_enable, set read_enable=1.
  - Required response: 0x4 reads 0xDEADBEEF and 0x8 reads 0xCAFEBABE, each valid in the same cycle the address is applied.
- Read gating: with 0xDEADBEEF at 0x4, read_enable=0 -> read_data=0x0; raising read_enable -> 0xDEADBEEF with no clock edge.
- Misaligned and out-of-range:
  - Reading 0x6 returns the word at 0x4.
  - Writing 0x12345678 to address DEPTH*4 leaves word 0 unchanged.
  - Reading address DEPTH*4 returns 0x0.
- Read-during-write: hold address 0x8 holding 0xCAFEBABE, read_enable=1, write_enable=1, write_data=0x11111111 -> read_data=0xCAFEBABE before the edge and 0x11111111 after it.
- Reset mid-operation: after several writes, assert rst while write_enable=1 -> all words read 0 after deassertion; the write pending during reset is not committed.
